// File: rtl/ws2812b_pixel_serializer.sv
// ws2812b_pixel_serializer: serializes 24-bit GRB pixels onto a WS2812B single-wire data line
//   clk          12.5 MHz system clock
//   reset        synchronous, active-high
//   pixel_data   GRB pixel, bit 23 (G7) sent first
//   pixel_valid  upstream offers pixel_data
//   pixel_ready  pixel accepted on the next edge when valid is also high
//   dout         registered WS2812B line, one cycle behind the FSM
//   busy         FSM is in SEND or LATCH
//   frame_done   one-cycle pulse after the latch period, aligned with the dout timeline
module ws2812b_pixel_serializer #(
    parameter int PIXELS       = 64,
    parameter int T0H_CYCLES   = 5,
    parameter int T1H_CYCLES   = 10,
    parameter int BIT_CYCLES   = 15,
    parameter int LATCH_CYCLES = 3600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);
    localparam int CMAX = BIT_CYCLES > LATCH_CYCLES ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int PW   = PIXELS > 1 ? $clog2(PIXELS) : 1;
    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
    state_t         state;
    logic [23:0]    shreg;
    logic [4:0]     bit_idx;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  pix_cnt;
    logic           latch_done;
    logic           bit_end;
    logic           latch_end;
    logic           bit_high;
    always_comb begin
        bit_end   = cnt == CW'(BIT_CYCLES - 1);
        latch_end = cnt == CW'(LATCH_CYCLES - 1);
        bit_high  = cnt < (shreg[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pixel_ready <= 1'b1;
            busy        <= 1'b0;
            dout        <= 1'b0;
            frame_done  <= 1'b0;
            latch_done  <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            pix_cnt     <= '0;
        end else begin
            // frame_done trails the LATCH->IDLE transition by one edge, like dout trails the FSM
            frame_done <= latch_done;
            latch_done <= 1'b0;
            dout       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pixel_valid && pixel_ready) begin
                        shreg       <= pixel_data;
                        bit_idx     <= 5'd23;
                        cnt         <= '0;
                        state       <= SEND;
                        pixel_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SEND: begin
                    dout <= bit_high;
                    if (!bit_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
                        shreg <= {shreg[22:0], 1'b0};
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 1'b1;
                        end else if (pix_cnt == PW'(PIXELS - 1)) begin
                            pix_cnt <= '0;
                            state   <= LATCH;
                        end else begin
                            pix_cnt     <= pix_cnt + 1'b1;
                            state       <= IDLE;
                            pixel_ready <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                end
                LATCH: begin
                    if (!latch_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt         <= '0;
                        state       <= IDLE;
                        pixel_ready <= 1'b1;
                        busy        <= 1'b0;
                        latch_done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
